axi_burst_tester: RTL and testbench

AXI_BURST_TESTER -- requirements
Module: axi_burst_tester

---
 rtl/axi_test_pkg.sv | 31 +++
 rtl/axi_pattern_gen.sv | 38 +++
 rtl/axi_burst_tester.sv | 218 +++++++++++++++++++++
 tb/tb_axi_burst_tester.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_test_pkg.sv
// Shared types and constants for the AXI burst tester: FSM state encoding,
// AXI burst/response codes, run-mode codes and a constant-friendly clog2.
package axi_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        FINISH
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [1:0] MODE_WR_RD   = 2'b00;
    localparam logic [1:0] MODE_WR_ONLY = 2'b01;
    localparam logic [1:0] MODE_RD_ONLY = 2'b10;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_pattern_gen.sv
// Incrementing data pattern: word n of a run is seed + n. The same generator
// drives write data and supplies the expected word for read-back checking.
module axi_pattern_gen #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic              restart_i,
    input  logic              advance_i,
    input  logic [DATA_W-1:0] cmp_data_i,
    output logic [DATA_W-1:0] word_o,
    output logic              mismatch_o
);

    logic [DATA_W-1:0] seed_q;
    logic [DATA_W-1:0] word_q;

    // Seed is kept so the read phase can replay the exact write sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            seed_q <= '0;
            word_q <= '0;
        end else if (load_i) begin
            seed_q <= seed_i;
            word_q <= seed_i;
        end else if (restart_i) begin
            word_q <= seed_q;
        end else if (advance_i) begin
            word_q <= word_q + 1'b1;
        end
    end

    assign word_o     = word_q;
    assign mismatch_o = (cmp_data_i != word_q);

endmodule

// File: rtl/axi_burst_tester.sv
// AXI4 master that writes NUM_BURSTS incrementing-pattern INCR bursts, then
// optionally reads them back and counts data/response/rlast errors.
module axi_burst_tester
    import axi_test_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                BURST_LEN  = 16,
    parameter int                NUM_BURSTS = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h4000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic [DATA_W-1:0]   seed,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [15:0]         err_cnt,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    localparam int                STRB_W      = DATA_W / 8;
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * STRB_W);
    localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [9:0]        LAST_BURST  = 10'(NUM_BURSTS - 1);
    localparam logic [2:0]        AXSIZE      = 3'(clog2(STRB_W));

    state_t              state_q, state_d;
    logic [7:0]          beat_q, beat_d;
    logic [9:0]          burst_q, burst_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          mode_q, mode_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic                error_q;
    logic [1:0]          err_inc;
    logic                pat_load, pat_restart, pat_advance;
    logic [DATA_W-1:0]   pat_word;
    logic                pat_mismatch;

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + 17'(inc);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    axi_pattern_gen #(
        .DATA_W(DATA_W)
    ) u_pattern (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pat_load),
        .seed_i     (seed),
        .restart_i  (pat_restart),
        .advance_i  (pat_advance),
        .cmp_data_i (m_axi_rdata),
        .word_o     (pat_word),
        .mismatch_o (pat_mismatch)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        state_d     = state_q;
        beat_d      = beat_q;
        burst_d     = burst_q;
        addr_d      = addr_q;
        mode_d      = mode_q;
        err_cnt_d   = err_cnt_q;
        err_inc     = 2'd0;
        pat_load    = 1'b0;
        pat_restart = 1'b0;
        pat_advance = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pat_load  = 1'b1;
                    mode_d    = mode;
                    beat_d    = '0;
                    burst_d   = '0;
                    addr_d    = BASE_ADDR;
                    err_cnt_d = '0;
                    state_d   = (mode == MODE_RD_ONLY) ? RD_ADDR : WR_ADDR;
                end
            end
            WR_ADDR: begin
                if (m_axi_awready) begin
                    beat_d  = '0;
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (m_axi_wready) begin
                    pat_advance = 1'b1;
                    beat_d      = beat_q + 8'd1;
                    if (beat_q == LAST_BEAT) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    err_inc = 2'(m_axi_bresp != AXI_RESP_OKAY);
                    if (burst_q == LAST_BURST) begin
                        burst_d     = '0;
                        addr_d      = BASE_ADDR;
                        pat_restart = 1'b1;
                        state_d     = (mode_q == MODE_WR_ONLY) ? FINISH : RD_ADDR;
                    end else begin
                        burst_d = burst_q + 10'd1;
                        addr_d  = addr_q + BURST_BYTES;
                        state_d = WR_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) begin
                    beat_d  = '0;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    // Data, response and rlast faults on one beat each count separately.
                    err_inc = 2'(pat_mismatch)
                            + 2'(m_axi_rresp != AXI_RESP_OKAY)
                            + 2'(m_axi_rlast != (beat_q == LAST_BEAT));
                    pat_advance = 1'b1;
                    beat_d      = beat_q + 8'd1;
                    if (beat_q == LAST_BEAT) begin
                        if (burst_q == LAST_BURST) begin
                            state_d = FINISH;
                        end else begin
                            burst_d = burst_q + 10'd1;
                            addr_d  = addr_q + BURST_BYTES;
                            state_d = RD_ADDR;
                        end
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        err_cnt_d = sat_add(err_cnt_d, err_inc);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            burst_q   <= '0;
            addr_q    <= BASE_ADDR;
            mode_q    <= MODE_WR_RD;
            err_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            burst_q   <= burst_d;
            addr_q    <= addr_d;
            mode_q    <= mode_d;
            err_cnt_q <= err_cnt_d;
            error_q   <= (err_cnt_d != 16'd0);
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FINISH);
    assign error   = error_q;
    assign err_cnt = err_cnt_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = LAST_BEAT;
    assign m_axi_awsize  = AXSIZE;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awvalid = (state_q == WR_ADDR);

    assign m_axi_wdata   = pat_word;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = (state_q == WR_DATA);
    assign m_axi_wlast   = (state_q == WR_DATA) && (beat_q == LAST_BEAT);
    assign m_axi_bready  = (state_q == WR_RESP);

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = LAST_BEAT;
    assign m_axi_arsize  = AXSIZE;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = (state_q == RD_ADDR);
    assign m_axi_rready  = (state_q == RD_DATA);

endmodule

// File: tb/tb_axi_burst_tester.sv
// Self-checking bench: behavioural AXI slave with memory plus a monitor, and
// scenario tasks comparing logged traffic against seed+n / BASE+k*bytes rules.
`timescale 1ns/1ps
module tb_axi_burst_tester;

    localparam int          DATA_W     = 32;
    localparam int          ADDR_W     = 32;
    localparam int          BURST_LEN  = 16;
    localparam int          NUM_BURSTS = 4;
    localparam logic [31:0] BASE       = 32'h4000_0000;
    localparam int          BEATS      = BURST_LEN * NUM_BURSTS;
    localparam int          BYTES      = BURST_LEN * DATA_W / 8;
    localparam int          TIMEOUT    = 5000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] seed = '0;
    logic        busy, done, error;
    logic [15:0] err_cnt;
    logic [31:0] awaddr, araddr, wdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, wlast, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic        bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    always #5 clk = ~clk;

    axi_burst_tester #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
        .NUM_BURSTS(NUM_BURSTS), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .seed(seed), .start(start),
        .busy(busy), .done(done), .error(error), .err_cnt(err_cnt),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] aw_log[$], ar_log[$], w_log[$];
    logic        wlast_log[$];
    int          r_cnt = 0, b_cnt = 0, rd_n = 0, done_cnt = 0, prop_err = 0, stab_err = 0;
    logic [15:0] done_err_cnt = '0;
    logic        done_error = 1'b0;
    bit          stall = 1'b0;
    int          corrupt_n = -1;
    int          slverr_b  = -1;
    logic [31:0] wr_addr = '0, rd_addr = '0;
    int          wr_beat = 0, rd_beat = 0;
    bit          b_pending = 1'b0, rd_active = 1'b0;
    bit          hold_aw = 1'b0, hold_w = 1'b0, hold_ar = 1'b0;
    logic [31:0] hold_awaddr = '0, hold_wdata = '0, hold_araddr = '0;
    logic        hold_wlast = 1'b0;

    function automatic logic [31:0] exp_addr(input int k);
        return BASE + 32'(k * BYTES);
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] s, input int n);
        return s + 32'(n);
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Slave drives at negedge; 1ns later the monitor records the handshakes
    // that the DUT will see at the following posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                b_pending = 0; rd_active = 0; hold_aw = 0; hold_w = 0; hold_ar = 0;
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                rlast = 0; rdata = '0; bresp = 2'b00; rresp = 2'b00;
            end else begin
                awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                bvalid  = b_pending;
                bresp   = (b_cnt == slverr_b) ? 2'b10 : 2'b00;
                rvalid  = rd_active && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
                rdata   = mem_read(rd_addr + 32'(rd_beat * 4)) ^ ((rd_n == corrupt_n) ? 32'h0000_0100 : 32'h0);
                rlast   = rd_active && (rd_beat == BURST_LEN - 1);
                rresp   = 2'b00;
                #1;
                if (done) begin
                    done_cnt++;
                    done_err_cnt = err_cnt;
                    done_error   = error;
                end
                if (hold_aw && (!awvalid || awaddr !== hold_awaddr)) stab_err++;
                if (hold_w && (!wvalid || wdata !== hold_wdata || wlast !== hold_wlast)) stab_err++;
                if (hold_ar && (!arvalid || araddr !== hold_araddr)) stab_err++;
                hold_aw = awvalid && !awready; hold_awaddr = awaddr;
                hold_w  = wvalid && !wready;   hold_wdata = wdata; hold_wlast = wlast;
                hold_ar = arvalid && !arready; hold_araddr = araddr;
                if (awvalid && awready) begin
                    aw_log.push_back(awaddr);
                    wr_addr = awaddr;
                    wr_beat = 0;
                    if (awlen !== 8'(BURST_LEN - 1) || awsize !== 3'd2 || awburst !== 2'b01) prop_err++;
                end
                if (wvalid && wready) begin
                    mem[wr_addr + 32'(wr_beat * 4)] = wdata;
                    w_log.push_back(wdata);
                    wlast_log.push_back(wlast);
                    if (wstrb !== 4'hF) prop_err++;
                    wr_beat++;
                    if (wr_beat == BURST_LEN) b_pending = 1;
                end
                if (bvalid && bready) begin
                    b_pending = 0;
                    b_cnt++;
                end
                if (arvalid && arready) begin
                    ar_log.push_back(araddr);
                    rd_addr   = araddr;
                    rd_beat   = 0;
                    rd_active = 1;
                    if (arlen !== 8'(BURST_LEN - 1) || arsize !== 3'd2 || arburst !== 2'b01) prop_err++;
                end
                if (rvalid && rready) begin
                    r_cnt++;
                    rd_n++;
                    rd_beat++;
                    if (rd_beat == BURST_LEN) rd_active = 0;
                end
            end
        end
    end

    task automatic clear_logs();
        aw_log.delete(); ar_log.delete(); w_log.delete(); wlast_log.delete();
        r_cnt = 0; b_cnt = 0; rd_n = 0; done_cnt = 0; prop_err = 0; stab_err = 0;
        done_err_cnt = '0; done_error = 1'b0;
    endtask

    task automatic run(input logic [1:0] m, input logic [31:0] s, input bit stl,
                       input bit poke_busy, output bit finished);
        clear_logs();
        stall = stl;
        @(posedge clk); #2;
        mode = m; seed = s; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; mode = 2'b01; seed = ~s;
        finished = 1'b0;
        for (int i = 0; i < TIMEOUT && !finished; i++) begin
            @(posedge clk); #2;
            start = (poke_busy && i == 20);
            if (done_cnt != 0) finished = 1'b1;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, busy, done, error} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000000",
                     {awvalid, wvalid, bready, arvalid, rready, busy, done, error});
        end
        n_checks++;
        if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d required 0", err_cnt); end
        n_checks++;
        if (awaddr !== BASE || araddr !== BASE) begin
            n_fail++; $display("FAIL reset_addr: aw %h ar %h required %h", awaddr, araddr, BASE);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_readback(input string tag, input logic [31:0] s,
                                       input bit stl, input bit poke);
        bit fin;
        run(2'b00, s, stl, poke, fin);
        n_checks++;
        if (fin !== 1'b1) begin n_fail++; $display("FAIL %s_timeout: done not seen within %0d cycles", tag, TIMEOUT); end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL %s_done_cnt: got %0d required 1", tag, done_cnt); end
        n_checks++;
        if (aw_log.size() !== NUM_BURSTS || ar_log.size() !== NUM_BURSTS) begin
            n_fail++; $display("FAIL %s_bursts: aw %0d ar %0d required %0d", tag, aw_log.size(), ar_log.size(), NUM_BURSTS);
        end
        n_checks++;
        if (w_log.size() !== BEATS || r_cnt !== BEATS) begin
            n_fail++; $display("FAIL %s_beats: w %0d r %0d required %0d", tag, w_log.size(), r_cnt, BEATS);
        end
        for (int k = 0; k < aw_log.size(); k++) begin
            n_checks++;
            if (aw_log[k] !== exp_addr(k)) begin n_fail++; $display("FAIL %s_awaddr[%0d]: got %h required %h", tag, k, aw_log[k], exp_addr(k)); end
        end
        for (int k = 0; k < ar_log.size(); k++) begin
            n_checks++;
            if (ar_log[k] !== exp_addr(k)) begin n_fail++; $display("FAIL %s_araddr[%0d]: got %h required %h", tag, k, ar_log[k], exp_addr(k)); end
        end
        for (int n = 0; n < w_log.size(); n++) begin
            n_checks++;
            if (w_log[n] !== exp_word(s, n)) begin n_fail++; $display("FAIL %s_wdata[%0d]: got %h required %h", tag, n, w_log[n], exp_word(s, n)); end
            n_checks++;
            if (wlast_log[n] !== 1'(n % BURST_LEN == BURST_LEN - 1)) begin
                n_fail++; $display("FAIL %s_wlast[%0d]: got %b required %b", tag, n, wlast_log[n], n % BURST_LEN == BURST_LEN - 1);
            end
        end
        n_checks++;
        if (done_err_cnt !== 16'd0 || done_error !== 1'b0 || err_cnt !== 16'd0) begin
            n_fail++; $display("FAIL %s_errors: err_cnt %0d error %b required 0 0", tag, done_err_cnt, done_error);
        end
        n_checks++;
        if (prop_err !== 0 || stab_err !== 0) begin
            n_fail++; $display("FAIL %s_protocol: attr errs %0d stability errs %0d required 0 0", tag, prop_err, stab_err);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle_busy: got %b required 0", tag, busy); end
    endtask

    task automatic test_corrupt();
        bit fin;
        corrupt_n = 2 * BURST_LEN + 5;
        run(2'b00, $urandom, 1'b0, 1'b0, fin);
        corrupt_n = -1;
        n_checks++;
        if (fin !== 1'b1 || done_cnt !== 1) begin n_fail++; $display("FAIL corrupt_done: done pulses %0d required 1", done_cnt); end
        n_checks++;
        if (done_err_cnt !== 16'd1) begin n_fail++; $display("FAIL corrupt_err_cnt: got %0d required 1", done_err_cnt); end
        n_checks++;
        if (done_error !== 1'b1) begin n_fail++; $display("FAIL corrupt_error: got %b required 1", done_error); end
    endtask

    task automatic test_wrap();
        test_write_readback("wrap", 32'hFFFF_FFFE, 1'b0, 1'b0);
        n_checks++;
        if (w_log.size() < 3 || w_log[0] !== 32'hFFFF_FFFE || w_log[1] !== 32'hFFFF_FFFF || w_log[2] !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_words: got %h %h %h required fffffffe ffffffff 00000000",
                     (w_log.size() > 0) ? w_log[0] : 32'hx, (w_log.size() > 1) ? w_log[1] : 32'hx,
                     (w_log.size() > 2) ? w_log[2] : 32'hx);
        end
    endtask

    // Memory still holds the wrap run's pattern; a read-only run with a shifted
    // seed must flag every beat, an unshifted one none.
    task automatic test_read_only();
        bit          fin;
        logic [31:0] s;
        int          exp_err;
        for (int v = 0; v < 2; v++) begin
            s       = 32'hFFFF_FFFE + ((v == 1) ? 32'($urandom_range(1, 1000)) : 32'h0);
            exp_err = (v == 1) ? BEATS : 0;
            run(2'b10, s, 1'b0, 1'b0, fin);
            n_checks++;
            if (fin !== 1'b1 || done_cnt !== 1) begin n_fail++; $display("FAIL rdonly%0d_done: done pulses %0d required 1", v, done_cnt); end
            n_checks++;
            if (aw_log.size() !== 0 || w_log.size() !== 0 || ar_log.size() !== NUM_BURSTS) begin
                n_fail++; $display("FAIL rdonly%0d_traffic: aw %0d w %0d ar %0d required 0 0 %0d", v, aw_log.size(), w_log.size(), ar_log.size(), NUM_BURSTS);
            end
            n_checks++;
            if (done_err_cnt !== 16'(exp_err) || done_error !== (exp_err != 0)) begin
                n_fail++; $display("FAIL rdonly%0d_errors: err_cnt %0d error %b required %0d %b", v, done_err_cnt, done_error, exp_err, exp_err != 0);
            end
        end
    endtask

    task automatic test_bresp_err();
        bit fin;
        slverr_b = 0;
        run(2'b01, $urandom, 1'b0, 1'b0, fin);
        slverr_b = -1;
        n_checks++;
        if (fin !== 1'b1 || done_cnt !== 1) begin n_fail++; $display("FAIL bresp_done: done pulses %0d required 1", done_cnt); end
        n_checks++;
        if (ar_log.size() !== 0 || r_cnt !== 0) begin n_fail++; $display("FAIL bresp_no_read: ar %0d r %0d required 0 0", ar_log.size(), r_cnt); end
        n_checks++;
        if (aw_log.size() !== NUM_BURSTS || w_log.size() !== BEATS) begin
            n_fail++; $display("FAIL bresp_writes: aw %0d w %0d required %0d %0d", aw_log.size(), w_log.size(), NUM_BURSTS, BEATS);
        end
        n_checks++;
        if (done_err_cnt !== 16'd1 || done_error !== 1'b1) begin
            n_fail++; $display("FAIL bresp_errors: err_cnt %0d error %b required 1 1", done_err_cnt, done_error);
        end
    endtask

    task automatic test_reset_mid();
        bit reached;
        clear_logs();
        stall = 1'b0;
        @(posedge clk); #2;
        mode = 2'b00; seed = $urandom; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(posedge clk); #2;
            if (w_log.size() >= 5) reached = 1'b1;
        end
        n_checks++;
        if (reached !== 1'b1 || wvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach: beats %0d wvalid %b required >=5 1", w_log.size(), wvalid); end
        rst = 1'b1;
        @(posedge clk); #2;
        n_checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, busy, done} !== 7'h00) begin
            n_fail++; $display("FAIL rstmid_ctrl: got %b required 0000000", {awvalid, wvalid, bready, arvalid, rready, busy, done});
        end
        n_checks++;
        if (awaddr !== BASE || err_cnt !== 16'd0 || error !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_state: awaddr %h err_cnt %0d error %b required %h 0 0", awaddr, err_cnt, error, BASE);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        test_write_readback("post_rst", $urandom, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_readback("basic", 32'h0, 1'b0, 1'b1);
        test_write_readback("stall", $urandom, 1'b1, 1'b0);
        test_corrupt();
        test_wrap();
        test_read_only();
        test_bresp_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
